// File: rtl/special_case_classifier.sv
// -----------------------------------------------------------------------------
// special_case_classifier
//
// Operand-side classifier for the HUB floating-point divider. Each accepted
// operand pair (X, Y) is tagged with a special-case code (NONE, +/-INF,
// +/-ZERO, +/-ONE) and handed to the divider datapath through a two-stage
// valid/ready pipeline with full backpressure.
//
//   Stage 1 : registers the operands plus raw per-operand decode flags.
//   Stage 2 : registers the operands, the encoded codes and any_special, and
//             drives every output.
//
// A saturating counter tracks how many delivered pairs took the special path.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        operand pair valid
//   in_ready        block can accept a pair this cycle
//   X, Y            operands {sign, exp[E-1:0], mant[M-1:0]}
//   out_valid       classified pair valid
//   out_ready       downstream accepts the pair
//   X_out, Y_out    registered operands
//   X_special_case  code for X_out
//   Y_special_case  code for Y_out
//   any_special     at least one of the two codes is not NONE
//   special_count   delivered pairs with any_special set, saturating
// -----------------------------------------------------------------------------
module special_case_classifier #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [E+M:0]                      X,
  input  logic [E+M:0]                      Y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [E+M:0]                      X_out,
  output logic [E+M:0]                      Y_out,
  output logic [$clog2(special_case)-1:0]   X_special_case,
  output logic [$clog2(special_case)-1:0]   Y_special_case,
  output logic                              any_special,
  output logic [CNT_W-1:0]                  special_count
);

  localparam int W  = E + M + 1;
  localparam int CW = $clog2(special_case);

  // Shared special-case encoding, identical to the divider's result selector.
  localparam logic [CW-1:0] CODE_NONE   = CW'(3'd0);
  localparam logic [CW-1:0] CODE_INF_P  = CW'(3'd1);
  localparam logic [CW-1:0] CODE_INF_N  = CW'(3'd2);
  localparam logic [CW-1:0] CODE_ZERO_P = CW'(3'd3);
  localparam logic [CW-1:0] CODE_ZERO_N = CW'(3'd4);
  localparam logic [CW-1:0] CODE_ONE_P  = CW'(3'd5);
  localparam logic [CW-1:0] CODE_ONE_N  = CW'(3'd6);

  // Biased exponent of 1.0: 2^(E-1)-1, i.e. 0111...1.
  localparam logic [E-1:0]     EXP_BIAS = {1'b0, {(E-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Raw decode of one operand, captured in stage 1 so that stage 2 only has
  // to do the priority encode.
  typedef struct packed {
    logic sign;
    logic exp_all_ones;
    logic exp_zero;
    logic exp_is_bias;
    logic mant_zero;
  } op_flags_t;

  // Decode the exponent/mantissa fields of one operand into flags.
  function automatic op_flags_t decode_f(input logic [W-1:0] op);
    op_flags_t     f;
    logic [E-1:0]  exp_v;
    logic [M-1:0]  mant_v;
    exp_v          = op[W-2:M];
    mant_v         = op[M-1:0];
    f.sign         = op[W-1];
    f.exp_all_ones = &exp_v;
    f.exp_zero     = ~|exp_v;
    f.exp_is_bias  = (exp_v == EXP_BIAS);
    f.mant_zero    = ~|mant_v;
    return f;
  endfunction

  // Priority encode: INF beats ZERO beats ONE; mantissa only matters for ONE.
  function automatic logic [CW-1:0] encode_f(input op_flags_t f);
    logic [CW-1:0] code;
    if (f.exp_all_ones) begin
      code = f.sign ? CODE_INF_N : CODE_INF_P;
    end else if (f.exp_zero) begin
      code = f.sign ? CODE_ZERO_N : CODE_ZERO_P;
    end else if (f.exp_is_bias && f.mant_zero) begin
      code = f.sign ? CODE_ONE_N : CODE_ONE_P;
    end else begin
      code = CODE_NONE;
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic            s1_valid_r;
  logic [W-1:0]    s1_x_r;
  logic [W-1:0]    s1_y_r;
  op_flags_t       s1_x_flags_r;
  op_flags_t       s1_y_flags_r;

  logic            s2_valid_r;
  logic [W-1:0]    s2_x_r;
  logic [W-1:0]    s2_y_r;
  logic [CW-1:0]   s2_x_code_r;
  logic [CW-1:0]   s2_y_code_r;
  logic            s2_any_r;

  logic [CNT_W-1:0] count_r;

  logic            s2_load_s;
  logic            s1_load_s;
  op_flags_t       in_x_flags_s;
  op_flags_t       in_y_flags_s;
  logic [CW-1:0]   s1_x_code_s;
  logic [CW-1:0]   s1_y_code_s;
  logic            s1_any_s;
  logic            out_fire_s;

  // Stage-advance control: a stage loads when it is empty or its contents
  // move on this cycle, so an empty S2 fills even while downstream stalls.
  always_comb begin
    s2_load_s  = 1'b0;
    s1_load_s  = 1'b0;
    out_fire_s = 1'b0;
    if (!s2_valid_r || out_ready) begin
      s2_load_s = 1'b1;
    end else begin
      s2_load_s = 1'b0;
    end
    if (!s1_valid_r || s2_load_s) begin
      s1_load_s = 1'b1;
    end else begin
      s1_load_s = 1'b0;
    end
    out_fire_s = s2_valid_r & out_ready;
  end

  // Field decode of the incoming operands ahead of stage 1.
  always_comb begin
    in_x_flags_s = decode_f(X);
    in_y_flags_s = decode_f(Y);
  end

  // Code encode of the stage-1 flags ahead of stage 2.
  always_comb begin
    s1_x_code_s = encode_f(s1_x_flags_r);
    s1_y_code_s = encode_f(s1_y_flags_r);
    s1_any_s    = (s1_x_code_s != CODE_NONE) || (s1_y_code_s != CODE_NONE);
  end

  // Stage 1 register: operands and raw flags, sampled only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_x_r       <= {W{1'b0}};
      s1_y_r       <= {W{1'b0}};
      s1_x_flags_r <= '{default: 1'b0};
      s1_y_flags_r <= '{default: 1'b0};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_x_r       <= X;
        s1_y_r       <= Y;
        s1_x_flags_r <= in_x_flags_s;
        s1_y_flags_r <= in_y_flags_s;
      end else begin
        s1_x_r       <= s1_x_r;
        s1_y_r       <= s1_y_r;
        s1_x_flags_r <= s1_x_flags_r;
        s1_y_flags_r <= s1_y_flags_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 register: operands, codes and any_special; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_x_r      <= {W{1'b0}};
      s2_y_r      <= {W{1'b0}};
      s2_x_code_r <= CODE_NONE;
      s2_y_code_r <= CODE_NONE;
      s2_any_r    <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_x_r      <= s1_x_r;
        s2_y_r      <= s1_y_r;
        s2_x_code_r <= s1_x_code_s;
        s2_y_code_r <= s1_y_code_s;
        s2_any_r    <= s1_any_s;
      end else begin
        s2_x_r      <= s2_x_r;
        s2_y_r      <= s2_y_r;
        s2_x_code_r <= s2_x_code_r;
        s2_y_code_r <= s2_y_code_r;
        s2_any_r    <= s2_any_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Saturating count of delivered pairs that took the special path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (out_fire_s && s2_any_r && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Output mapping: everything except in_ready comes straight from registers.
  always_comb begin
    in_ready       = s1_load_s;
    out_valid      = s2_valid_r;
    X_out          = s2_x_r;
    Y_out          = s2_y_r;
    X_special_case = s2_x_code_r;
    Y_special_case = s2_y_code_r;
    any_special    = s2_any_r;
    special_count  = count_r;
  end

endmodule

// File: tb/tb_special_case_classifier.sv
module tb_special_case_classifier;

  localparam int M = 23;
  localparam int E = 8;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  X_out;
  logic [W-1:0]  Y_out;
  logic [2:0]    X_special_case;
  logic [2:0]    Y_special_case;
  logic          any_special;
  logic [15:0]   special_count;

  // Second instance with a 2-bit counter, fed the same stimulus.
  logic          in_ready2;
  logic          out_valid2;
  logic [W-1:0]  X_out2;
  logic [W-1:0]  Y_out2;
  logic [2:0]    X_sc2;
  logic [2:0]    Y_sc2;
  logic          any2;
  logic [1:0]    count2;

  special_case_classifier #(.M(M), .E(E), .special_case(7), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .X_out(X_out), .Y_out(Y_out), .X_special_case(X_special_case),
    .Y_special_case(Y_special_case), .any_special(any_special),
    .special_count(special_count)
  );

  special_case_classifier #(.M(M), .E(E), .special_case(7), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .X(X), .Y(Y), .out_valid(out_valid2), .out_ready(out_ready),
    .X_out(X_out2), .Y_out(Y_out2), .X_special_case(X_sc2),
    .Y_special_case(Y_sc2), .any_special(any2),
    .special_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   xc;
    logic [2:0]   yc;
  } vec_t;

  vec_t         sb[$];
  logic [1:0]   cnt2_log[$];
  int           checks;
  int           errors;
  logic [15:0]  mcnt;
  logic [1:0]   mcnt2;
  logic         log_pending;
  logic         saw_full;
  logic [2:0]   cur_xc;
  logic [2:0]   cur_yc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classifier written directly from the IEEE-754 single layout.
  function automatic logic [2:0] ref_code(input logic [31:0] v);
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'hFF) return v[31] ? 3'd2 : 3'd1;
    if (e == 8'h00) return v[31] ? 3'd4 : 3'd3;
    if (e == 8'h7F && v[22:0] == 23'd0) return v[31] ? 3'd6 : 3'd5;
    return 3'd0;
  endfunction

  // Scoreboard monitor: samples mid-cycle, pushes on input handshakes and
  // compares the head on every valid output (so stalled outputs must hold).
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mcnt        = 16'd0;
      mcnt2       = 2'd0;
      log_pending = 1'b0;
    end else begin
      check("special_count", {48'd0, special_count}, {48'd0, mcnt});
      check("special_count_w2", {62'd0, count2}, {62'd0, mcnt2});
      if (log_pending) begin
        cnt2_log.push_back(count2);
        log_pending = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          check("X_out", {32'd0, X_out}, {32'd0, sb[0].x});
          check("Y_out", {32'd0, Y_out}, {32'd0, sb[0].y});
          check("X_code", {61'd0, X_special_case}, {61'd0, sb[0].xc});
          check("Y_code", {61'd0, Y_special_case}, {61'd0, sb[0].yc});
          check("any_special", {63'd0, any_special},
                {63'd0, (sb[0].xc != 3'd0) || (sb[0].yc != 3'd0)});
          if (out_ready) begin
            if ((sb[0].xc != 3'd0) || (sb[0].yc != 3'd0)) begin
              if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
              if (mcnt2 != 2'd3) mcnt2 = mcnt2 + 2'd1;
              log_pending = 1'b1;
            end
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{X, Y, cur_xc, cur_yc});
      if (in_valid && !in_ready) saw_full = 1'b1;
    end
  end

  // Drive one pair and hold it until it is accepted (bounded).
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2:0] xc, input logic [2:0] yc);
    logic hs;
    int   n;
    in_valid = 1'b1;
    X = x; Y = y; cur_xc = xc; cur_yc = yc;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", {32'd0, sb.size()}, 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    checks = 0; errors = 0; saw_full = 1'b0;
    mcnt = 16'd0; mcnt2 = 2'd0; log_pending = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    X = 32'd0; Y = 32'd0; cur_xc = 3'd0; cur_yc = 3'd0;
    rst_n = 1'b0;

    tbl[0] = '{32'h3F800000, 32'hBF800000, 3'd5, 3'd6};
    tbl[1] = '{32'h7FFFFFFF, 32'hFF800000, 3'd1, 3'd2};
    tbl[2] = '{32'h00000000, 32'h80000001, 3'd3, 3'd4};
    tbl[3] = '{32'h40000000, 32'h3F800001, 3'd0, 3'd0};
    tbl[4] = '{32'h7F800000, 32'h80000000, 3'd1, 3'd4};
    tbl[5] = '{32'h3FFFFFFF, 32'h00800000, 3'd0, 3'd0};
    tbl[6] = '{32'hBF800000, 32'h7F7FFFFF, 3'd6, 3'd0};
    tbl[7] = '{32'h007FFFFF, 32'hFFFFFFFF, 3'd3, 3'd2};

    // Reset state
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_X_out", {32'd0, X_out}, 64'd0);
    check("rst_codes", {58'd0, X_special_case, Y_special_case}, 64'd0);
    check("rst_any", {63'd0, any_special}, 64'd0);
    check("rst_count", {48'd0, special_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: latency of the first pair and counter step
    begin
      int n;
      in_valid = 1'b1; X = tbl[0].x; Y = tbl[0].y; cur_xc = tbl[0].xc; cur_yc = tbl[0].yc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("latency_first", n, 64'd2);
      check("count_before", {48'd0, special_count}, 64'd0);
      @(posedge clk); #1;
      check("count_after", {48'd0, special_count}, 64'd1);
    end
    drain();

    // Table vectors, back to back at full throughput
    for (int i = 0; i < 8; i++) send(tbl[i].x, tbl[i].y, tbl[i].xc, tbl[i].yc);
    drain();

    // Test 4: six pairs with out_ready low for cycles 3-6
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] a, b;
          a = (i % 2 == 0) ? tbl[i].x : $urandom;
          b = tbl[5 - i].y;
          send(a, b, ref_code(a), ref_code(b));
        end
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_fell", {63'd0, saw_full}, 64'd1);

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a, b;
          a = (i % 3 == 0) ? tbl[$urandom_range(7)].x : $urandom;
          b = (i % 4 == 1) ? tbl[$urandom_range(7)].y : $urandom;
          send(a, b, ref_code(a), ref_code(b));
        end
      end
      begin
        repeat (80) begin @(posedge clk); #1; out_ready = ($urandom_range(3) != 0); end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Test 5: reset with both stages full
    out_ready = 1'b0;
    send(tbl[0].x, tbl[0].y, tbl[0].xc, tbl[0].yc);
    send(tbl[1].x, tbl[1].y, tbl[1].xc, tbl[1].yc);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_out_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_count", {48'd0, special_count}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    begin
      int n;
      in_valid = 1'b1; X = tbl[3].x; Y = tbl[3].y; cur_xc = tbl[3].xc; cur_yc = tbl[3].yc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("latency_after_rst", n, 64'd2);
      check("post_rst_X_out", {32'd0, X_out}, {32'd0, tbl[3].x});
    end
    drain();

    // Test 6: 2-bit counter saturates
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt2_log.delete();
    for (int i = 0; i < 5; i++) send(tbl[i % 3].x, tbl[i % 3].y, tbl[i % 3].xc, tbl[i % 3].yc);
    drain();
    @(posedge clk); #1;
    check("cnt2_log_size", {32'd0, cnt2_log.size()}, 64'd5);
    begin
      logic [1:0] exp_seq[5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        if (i < cnt2_log.size()) check("cnt2_seq", {62'd0, cnt2_log[i]}, {62'd0, exp_seq[i]});
      end
    end
    check("cnt16_five", {48'd0, special_count}, 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/special_case_classifier.md
Name: special_case_classifier

Overview:
- Operand-side counterpart of the divider's special-result selector. Classifies each incoming HUB floating-point operand pair (X, Y) into the shared special-case codes (NONE, ±INF, ±ZERO, ±ONE).
- Registers the codes alongside the operands for the divider datapath.
- Two-stage valid/ready pipeline with full backpressure. Also maintains a saturating count of operand pairs that hit the special path.

Parameters:
- M, 23, mantissa width.
- E, 8, exponent width.
- special_case, 7, number of special-case codes; code width CW = $clog2(special_case).
- CNT_W, 16, width of the special-pair counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- X  in  E+M+1  operand X {sign, exp[E-1:0], mant[M-1:0]}.
- Y  in  E+M+1  operand Y, same layout.
- out_valid  out  1  classified pair valid.
- out_ready  in  1  downstream accepts.
- X_out  out  E+M+1  registered X.
- Y_out  out  E+M+1  registered Y.
- X_special_case  out  CW  code for X_out.
- Y_special_case  out  CW  code for Y_out.
- any_special  out  1  X_special_case != NONE or Y_special_case != NONE.
- special_count  out  CNT_W  number of accepted output pairs with any_special = 1; saturates.

Behaviour:
- Codes: NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6. Value 7 is never produced.
- Classification is per operand, in priority order:
  - exp all ones -> INF (sign selects P/N), regardless of mantissa.
  - else exp == 0 -> ZERO (sign selects P/N), regardless of mantissa.
  - else exp == 2^(E-1)-1 and mant == 0 -> ONE (sign selects P/N).
  - else NONE.
- Stage 1 (S1) registers the operands plus per-operand flags: exp_all_ones, exp_zero, exp_is_bias, mant_zero, sign.
- Stage 2 (S2) registers the operands, the encoded codes and any_special. S2 drives all outputs.
- Stage advance rules:
  - S2 loads when s2_valid == 0 or out_ready == 1.
  - S1 loads when s1_valid == 0 or S2 loads.
  - in_ready = S1 loads (combinational from out_ready and the valid bits).
- Latency: 2 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 pair per cycle when out_ready is held high.
- Backpressure:
  - While out_valid == 1 and out_ready == 0, X_out, Y_out, codes and any_special hold stable.
  - No pair is dropped or duplicated.
  - Up to 2 pairs are buffered, and in_ready falls when both stages are full.
- Bubbles: an empty S2 loads from S1 even while out_ready == 0.
- special_count:
  - Increments by 1 on each output handshake (out_valid & out_ready) with any_special == 1.
  - Holds at 2^CNT_W-1.
- Reset (async assert, synchronous-release usage):
  - s1_valid, s2_valid, out_valid = 0.
  - X_out, Y_out = 0; codes = NONE; any_special = 0; special_count = 0.
  - in_ready = 1 after reset.
  - Reset asserted mid-stream discards all in-flight pairs. No output handshake occurs in the cycle reset is asserted.
- Input data is sampled only when in_valid & in_ready. X and Y are don't-care otherwise.

Test Plan:
1. E=8, M=23: X=0x3F800000, Y=0xBF800000, out_ready=1 -> 2 cycles later out_valid=1, X_special_case=5, Y_special_case=6, any_special=1, special_count 0->1.
2. X=0x7FFFFFFF, Y=0xFF800000 -> codes 1 and 2. X=0x00000000, Y=0x80000001 -> codes 3 and 4.
3. X=0x40000000, Y=0x3F800001 -> both codes 0, any_special=0, special_count unchanged.
4. Stream of 6 pairs with out_ready=0 for cycles 3-6 -> in_ready=0 once 2 pairs are held, outputs stable while stalled, all 6 pairs emerge in order with correct codes after out_ready returns to 1.
5. Assert rst_n=0 with both stages full -> out_valid=0 and special_count=0 immediately. After release, the next pair appears after exactly 2 cycles with no stale data.
6. CNT_W=2, five consecutive special pairs accepted -> special_count reads 1, 2, 3, 3, 3.
